// File: rtl/vga_line_buffer.sv
// vga_line_buffer: ping-pong RGB332 line buffer between a raster-order pixel stream and VGA scan-out
module vga_line_buffer #(
  parameter int HPIXELS = 800,
  parameter int VLINES  = 521,
  parameter int HBP     = 144,
  parameter int HFP     = 784,
  parameter int VBP     = 31,
  parameter int VFP     = 511
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic [7:0] wr_data,
  input  logic       wr_sof,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       underrun
);
  localparam int LINE = HFP - HBP;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] FULL = 2'd2;
  localparam logic [9:0] H_LAST  = 10'(HPIXELS - 1);
  localparam logic [9:0] H_BP    = 10'(HBP);
  localparam logic [9:0] H_FP    = 10'(HFP);
  localparam logic [9:0] V_BP    = 10'(VBP);
  localparam logic [9:0] V_FP    = 10'(VFP);
  localparam logic [9:0] V_SW_LO = 10'(VBP - 1);
  localparam logic [9:0] V_SW_HI = 10'(VFP - 1);
  localparam logic [9:0] W_LAST  = 10'(LINE - 1);

  if (VFP >= VLINES || HFP >= HPIXELS) begin : g_bad_cfg
    $error("vga_line_buffer: active window does not fit inside the frame");
  end

  logic [7:0] mem0 [LINE];
  logic [7:0] mem1 [LINE];
  logic [1:0] state_q, state_d;
  logic [9:0] wcnt_q, wcnt_d;
  logic       sel_q, sel_d, fv_q, fv_d, underrun_q, underrun_d;
  logic [7:0] pix_q, pix_d;
  logic       hs, line_end, swap_evt, end_evt, active, we;
  logic [9:0] waddr, raddr;
  logic [7:0] rdata;

  assign wr_ready = ~clr & (state_q != FULL);
  assign hs       = wr_valid & wr_ready;
  assign line_end = hc == H_LAST;
  assign swap_evt = line_end && vc >= V_SW_LO && vc < V_SW_HI;
  assign end_evt  = line_end && vc == V_SW_HI;
  assign active   = hc >= H_BP && hc < H_FP && vc >= V_BP && vc < V_FP && fv_q;
  assign raddr    = hc - H_BP;
  assign rdata    = sel_q ? mem1[raddr] : mem0[raddr];
  assign {red, green, blue} = pix_q;
  assign underrun = underrun_q;

  // Write FSM: accept pixels into the back line, then swap or flag underrun at line end
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    sel_d      = sel_q;
    fv_d       = fv_q;
    underrun_d = 1'b0;
    we         = 1'b0;
    waddr      = wcnt_q;
    pix_d      = active ? rdata : 8'd0;
    if (hs && (wr_sof || state_q == FILL)) begin
      we      = 1'b1;
      waddr   = wr_sof ? 10'd0 : wcnt_q;
      wcnt_d  = waddr + 10'd1;
      state_d = (!wr_sof && wcnt_q == W_LAST) ? FULL : FILL;
    end
    if (swap_evt) begin
      if (state_d == FULL) begin
        sel_d   = ~sel_q;
        fv_d    = 1'b1;
        wcnt_d  = 10'd0;
        state_d = FILL;
      end else begin
        fv_d = 1'b0;
        if (state_q == FILL) begin
          underrun_d = 1'b1;
          state_d    = IDLE;
          wcnt_d     = 10'd0;
        end
      end
    end
    if (end_evt) fv_d = 1'b0;
  end

  // Control and colour registers, cleared asynchronously by clr
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      wcnt_q     <= 10'd0;
      sel_q      <= 1'b0;
      fv_q       <= 1'b0;
      underrun_q <= 1'b0;
      pix_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      sel_q      <= sel_d;
      fv_q       <= fv_d;
      underrun_q <= underrun_d;
      pix_q      <= pix_d;
    end
  end

  // Line storage: writes always target the back line (the one not selected by sel)
  always_ff @(posedge dclk) begin
    if (we && sel_q) mem0[waddr] <= wr_data;
    if (we && !sel_q) mem1[waddr] <= wr_data;
  end
endmodule
